// File: rtl/ipm_distributed_fifo_fwft_v1_0.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ipm_distributed_fifo_fwft_v1_0
//  Purpose  : Read-side prefetch stage for the distributed FIFO. Issues reads
//             to the FIFO controller while credit is available, captures the
//             RAM data after a fixed read latency into a 4-entry skid buffer,
//             and presents the buffer head as a first-word-fall-through
//             valid/ready stream at up to one word per rd_clk.
//  Ports    :
//    rd_clk    in   read clock, rising edge
//    rrst      in   synchronous active-high reset
//    rempty    in   controller read-empty flag
//    r_en      out  read enable to controller (combinational)
//    rd_data   in   RAM read data, valid RD_LATENCY edges after acceptance
//    m_valid   out  stream word valid
//    m_ready   in   downstream accepts the word
//    m_data    out  stream word (buffer head)
//    buf_level out  words held in the skid buffer, 0..4
//    inflight  out  accepted reads not yet captured, 0..RD_LATENCY
//  Revision : 1.0 - initial release
// ============================================================================
module ipm_distributed_fifo_fwft_v1_0 #(
   parameter int DATA_WIDTH = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                  rd_clk,
   input  logic                  rrst,
   input  logic                  rempty,
   output logic                  r_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [2:0]            buf_level,
   output logic [1:0]            inflight
);

   localparam int         BUF_DEPTH = 4;
   localparam logic [3:0] C_DEPTH   = 4'd4;

   logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
   logic [1:0]            r_wr_ptr;
   logic [1:0]            r_rd_ptr;
   logic [2:0]            r_level;
   // One bit per read-latency stage: bit i set means a read accepted i+1
   // edges ago has not yet been captured.
   logic [RD_LATENCY-1:0] r_vld_pipe;

   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic [1:0]            w_inflight;
   logic [3:0]            w_committed;

   always_comb begin
      w_inflight = 2'd0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         w_inflight = w_inflight + {1'b0, r_vld_pipe[i]};
      end
   end

   // Credit counts both buffered words and reads still in the RAM pipeline,
   // so a capture always finds a free slot. A same-cycle pop earns no credit,
   // which keeps r_en free of any path from m_ready.
   assign w_committed = {1'b0, r_level} + {2'b00, w_inflight};
   assign r_en        = !rrst && !rempty && (w_committed < C_DEPTH);

   assign w_accept    = r_en;
   assign w_push      = r_vld_pipe[RD_LATENCY-1];
   assign m_valid     = (r_level != 3'd0);
   assign w_pop       = m_valid && m_ready;
   assign m_data      = r_buf[r_rd_ptr];
   assign buf_level   = r_level;
   assign inflight    = w_inflight;

   always_ff @(posedge rd_clk) begin
      if (rrst) begin
         r_vld_pipe <= '0;
         r_wr_ptr   <= 2'd0;
         r_rd_ptr   <= 2'd0;
         r_level    <= 3'd0;
      end else begin
         r_vld_pipe[0] <= w_accept;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 3'd1;
            2'b01:   r_level <= r_level - 3'd1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage is not reset; only the pointers and level define its contents.
   // The reset guard drops data returning for reads issued before reset.
   always_ff @(posedge rd_clk) begin
      if (!rrst && w_push) begin
         r_buf[r_wr_ptr] <= rd_data;
      end
   end

endmodule
`default_nettype wire
